// File: rtl/sm_agm_if.sv
// Bus of sm_agm_top: frame control and pixel input toward the block,
// BRAM address/enable status and processed pixel results back out.
interface sm_agm_if #(parameter int ADDR_W = 10);
  logic              start;
  logic [31:0]       module_in;
  logic [2:0]        sel_mux;
  logic              wea;
  logic              en_wr;
  logic              en_rd;
  logic [ADDR_W-1:0] W_BRAM_ADDR;
  logic [ADDR_W-1:0] R_BRAM_ADDR;
  logic              pause;
  logic              out_valid;
  logic [7:0]        out1, out2, out3, out4, out5, out6, out7, out8;

  modport master (
    output start, module_in, sel_mux,
    input  wea, en_wr, en_rd, W_BRAM_ADDR, R_BRAM_ADDR, pause, out_valid,
    input  out1, out2, out3, out4, out5, out6, out7, out8
  );

  modport slave (
    input  start, module_in, sel_mux,
    output wea, en_wr, en_rd, W_BRAM_ADDR, R_BRAM_ADDR, pause, out_valid,
    output out1, out2, out3, out4, out5, out6, out7, out8
  );
endinterface

// File: rtl/sm_agm_top.sv
// Frame buffer: captures DEPTH packed-pixel words into BRAM, then reads them
// back through a per-byte pixel operation plus a word-to-word difference.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   WRITE | capturing module_in, one word per cycle
//   READ  | issuing read addresses, one per cycle
//   DONE  | frame finished, outputs held until start
module sm_agm_top #(
  parameter int         ADDR_W = 10,
  parameter int         DEPTH  = 1024,
  parameter logic [7:0] BRIGHT = 8'd50,
  parameter logic [7:0] THRESH = 8'd128
) (
  input logic   clk,
  input logic   reset,
  sm_agm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              wr_last;
  logic              idle_like;
  logic [3:0][7:0]   cur, diff, res_q, diff_q, prev_q;

  function automatic logic [7:0] pix_op(input logic [7:0] p, input logic [2:0] sel);
    logic [8:0] sum;
    sum = {1'b0, p} + {1'b0, BRIGHT};
    case (sel)
      3'd1:    pix_op = ~p;
      3'd2:    pix_op = sum[8] ? 8'hFF : sum[7:0];
      3'd3:    pix_op = (p > BRIGHT) ? (p - BRIGHT) : 8'h00;
      3'd4:    pix_op = (p >= THRESH) ? 8'hFF : 8'h00;
      3'd5:    pix_op = {1'b0, p[7:1]};
      default: pix_op = p;
    endcase
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE);
  assign wr_last   = (state == WRITE) && (w_addr == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start)       state_nxt = WRITE;
      WRITE:      if (w_addr == LAST)  state_nxt = READ;
      READ:       if (r_addr == LAST)  state_nxt = DONE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Counters saturate at the last word so a frame never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr <= '0;
      r_addr <= '0;
    end else begin
      if (idle_like && bus.start)
        w_addr <= '0;
      else if (state == WRITE && w_addr != LAST)
        w_addr <= w_addr + 1'b1;

      if (wr_last)
        r_addr <= '0;
      else if (state == READ && r_addr != LAST)
        r_addr <= r_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WRITE) mem[w_addr] <= bus.module_in;
    if (state == READ)  rd_data     <= mem[r_addr];
  end

  always_comb begin
    cur  = '0;
    diff = '0;
    for (int k = 0; k < 4; k++) begin
      cur[k]  = pix_op(rd_data[8*k +: 8], bus.sel_mux);
      diff[k] = (cur[k] >= prev_q[k]) ? (cur[k] - prev_q[k]) : (prev_q[k] - cur[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      res_q         <= '0;
      diff_q        <= '0;
      prev_q        <= '0;
    end else begin
      rd_valid      <= (state == READ);
      bus.out_valid <= rd_valid;
      if (wr_last) begin
        prev_q <= '0;
      end else if (rd_valid) begin
        res_q  <= cur;
        diff_q <= diff;
        prev_q <= cur;
      end
    end
  end

  assign bus.wea         = (state == WRITE);
  assign bus.en_wr       = (state == WRITE);
  assign bus.en_rd       = (state == READ);
  assign bus.pause       = idle_like;
  assign bus.W_BRAM_ADDR = w_addr;
  assign bus.R_BRAM_ADDR = r_addr;
  assign bus.out1 = res_q[0];
  assign bus.out2 = res_q[1];
  assign bus.out3 = res_q[2];
  assign bus.out4 = res_q[3];
  assign bus.out5 = diff_q[0];
  assign bus.out6 = diff_q[1];
  assign bus.out7 = diff_q[2];
  assign bus.out8 = diff_q[3];

endmodule

// File: tb/tb_sm_agm_top.sv
// Bench for sm_agm_top with a 4-word frame: directed scenarios plus random
// frames checked against a per-frame arithmetic pixel model.
module tb_sm_agm_top;
  localparam int AW  = 3;
  localparam int DEP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sm_agm_if #(.ADDR_W(AW)) bus();

  sm_agm_top #(.ADDR_W(AW), .DEPTH(DEP), .BRIGHT(8'd50), .THRESH(8'd128)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [2:0]  sel_last;
  logic [63:0] cap [2];
  logic [63:0] last_exp;
  logic [31:0] wds [DEP];

  function automatic int ref_op(input int p, input int s);
    case (s)
      1:       return 255 - p;
      2:       return (p + 50 > 255) ? 255 : p + 50;
      3:       return (p - 50 < 0) ? 0 : p - 50;
      4:       return (p >= 128) ? 255 : 0;
      5:       return p / 2;
      default: return p;
    endcase
  endfunction

  function automatic logic [63:0] outs();
    return {bus.out1, bus.out2, bus.out3, bus.out4, bus.out5, bus.out6, bus.out7, bus.out8};
  endfunction

  task automatic do_write(input logic [31:0] w [DEP], input logic [2:0] s, input logic hold);
    bus.start = 1'b1; bus.module_in = $urandom; bus.sel_mux = s;
    @(negedge clk);
    total++;
    if (bus.pause !== 1'b1) begin bad++; $display("FAIL pause_before_write got=%b exp=1", bus.pause); end
    for (int i = 0; i < DEP; i++) begin
      @(posedge clk); #1;
      bus.start = hold; bus.module_in = w[i];
      @(negedge clk);
      total++;
      if ({bus.wea, bus.en_wr, bus.en_rd, bus.pause, bus.W_BRAM_ADDR} !== {4'b1100, AW'(i)}) begin
        bad++;
        $display("FAIL write_cycle%0d got wea/en_wr/en_rd/pause/addr=%b%b%b%b/%0d exp=1100/%0d",
                 i, bus.wea, bus.en_wr, bus.en_rd, bus.pause, bus.W_BRAM_ADDR, i);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0; sel_last = s;
  endtask

  task automatic do_read(input logic [31:0] w [DEP], input logic rnd, input logic [2:0] s);
    int          prevv [4];
    int          k, px, v;
    logic [2:0]  cur;
    logic        e_rd, e_pause, e_valid;
    logic [AW-1:0] e_addr;
    logic [63:0] e;
    for (int b = 0; b < 4; b++) prevv[b] = 0;
    for (int c = 0; c < 10; c++) begin
      cur = rnd ? 3'($urandom_range(0, 7)) : s;
      bus.sel_mux = cur;
      @(negedge clk);
      e_rd    = (c < DEP);
      e_pause = (c >= DEP);
      e_valid = (c >= 2) && (c < DEP + 2);
      e_addr  = AW'((c < DEP) ? c : DEP - 1);
      total++;
      if ({bus.en_rd, bus.pause, bus.out_valid, bus.R_BRAM_ADDR} !== {e_rd, e_pause, e_valid, e_addr}) begin
        bad++;
        $display("FAIL read_ctrl_c%0d got en_rd/pause/valid/addr=%b%b%b/%0d exp=%b%b%b/%0d",
                 c, bus.en_rd, bus.pause, bus.out_valid, bus.R_BRAM_ADDR, e_rd, e_pause, e_valid, e_addr);
      end
      if (e_valid) begin
        k = c - 2;
        e = '0;
        for (int b = 0; b < 4; b++) begin
          px = int'((w[k] >> (8 * b)) & 32'hFF);
          v  = ref_op(px, int'(sel_last));
          e[63 - 8*b -: 8] = 8'(v);
          e[31 - 8*b -: 8] = 8'((v >= prevv[b]) ? v - prevv[b] : prevv[b] - v);
          prevv[b] = v;
        end
        last_exp = e;
        if (k < 2) cap[k] = outs();
      end
      total++;
      if (outs() !== last_exp) begin
        bad++;
        $display("FAIL outputs_c%0d got=%h exp=%h", c, outs(), last_exp);
      end
      sel_last = cur;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.module_in = '0; bus.sel_mux = '0;
    reset = 1'b1; last_exp = '0;
    #3;
    total++;
    if ({bus.wea, bus.en_wr, bus.en_rd, bus.pause, bus.out_valid, bus.W_BRAM_ADDR, bus.R_BRAM_ADDR, outs()}
        !== {5'b00010, {AW{1'b0}}, {AW{1'b0}}, 64'h0}) begin
      bad++; $display("FAIL reset_state got pause=%b valid=%b outs=%h", bus.pause, bus.out_valid, outs());
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < DEP; i++) wds[i] = 32'h0000_0929;
    do_write(wds, 3'd0, 1'b0);
    do_read(wds, 1'b0, 3'd0);
    total++;
    if (cap[0] !== 64'h2909_0000_2909_0000) begin bad++; $display("FAIL pass_first got=%h exp=2909000029090000", cap[0]); end
    total++;
    if (cap[1] !== 64'h2909_0000_0000_0000) begin bad++; $display("FAIL pass_second got=%h exp=2909000000000000", cap[1]); end
  endtask

  task automatic test_sel_sweep();
    logic [31:0] tbl [3];
    tbl[0] = 32'hD6F6_FFFF; tbl[1] = 32'h5B3B_3232; tbl[2] = 32'h0000_0000;
    for (int i = 0; i < DEP; i++) wds[i] = 32'h0000_0929;
    for (int s = 1; s <= 3; s++) begin
      do_write(wds, 3'(s), 1'b0);
      do_read(wds, 1'b0, 3'(s));
      total++;
      if (cap[0] !== {tbl[s-1], tbl[s-1]}) begin
        bad++; $display("FAIL sweep_sel%0d got=%h exp=%h%h", s, cap[0], tbl[s-1], tbl[s-1]);
      end
    end
  endtask

  task automatic test_thresh_diff();
    wds[0] = 32'h80FF_7F00; wds[1] = '0; wds[2] = '0; wds[3] = '0;
    do_write(wds, 3'd4, 1'b0);
    do_read(wds, 1'b0, 3'd4);
    total++;
    if (cap[0][63:32] !== 32'h0000_FFFF) begin bad++; $display("FAIL thresh_word1 got=%h exp=0000ffff", cap[0][63:32]); end
    total++;
    if (cap[1][31:0] !== 32'h0000_FFFF) begin bad++; $display("FAIL diff_word2 got=%h exp=0000ffff", cap[1][31:0]); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < DEP; i++) wds[i] = $urandom;
      do_write(wds, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      do_read(wds, 1'b1, 3'd0);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < DEP; i++) wds[i] = $urandom | 32'h0101_0101;
    do_write(wds, 3'd0, 1'b0);
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({bus.wea, bus.en_wr, bus.en_rd, bus.pause, bus.out_valid, bus.W_BRAM_ADDR, bus.R_BRAM_ADDR, outs()}
        !== {5'b00010, {AW{1'b0}}, {AW{1'b0}}, 64'h0}) begin
      bad++; $display("FAIL reset_mid_read got pause=%b valid=%b waddr=%0d outs=%h",
                      bus.pause, bus.out_valid, bus.W_BRAM_ADDR, outs());
    end
    last_exp = '0;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({bus.wea, bus.en_rd, bus.pause, bus.out_valid, outs()} !== {4'b0010, 64'h0}) begin
        bad++; $display("FAIL idle_after_reset_c%0d got wea/en_rd/pause/valid=%b%b%b%b", c,
                        bus.wea, bus.en_rd, bus.pause, bus.out_valid);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < DEP; i++) wds[i] = $urandom;
    do_write(wds, 3'd2, 1'b0);
    do_read(wds, 1'b1, 3'd2);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sel_sweep();
    test_thresh_diff();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
